// File: rtl/controlador_barrido_pkg.sv
// Shared display definitions for the 4-digit 7-segment scan path.
// Holds the digit count, the blank code the downstream decoder understands,
// the digit index constants and the leading-zero suppression helper.
package controlador_barrido_pkg;

    localparam int         N_DIGITOS     = 4;
    localparam logic [3:0] CODIGO_BLANCO = 4'hF;

    localparam logic [1:0] CIFRA_1 = 2'd0;
    localparam logic [1:0] CIFRA_2 = 2'd1;
    localparam logic [1:0] CIFRA_3 = 2'd2;
    localparam logic [1:0] CIFRA_4 = 2'd3;

    // Walks from the most significant digit down and blanks zeros until the
    // first non-zero digit. Digit 1 (index 0) is never blanked, so a value of
    // zero still shows a single '0'.
    function automatic logic [15:0] suprimir_ceros(input logic [15:0] i_v);
        logic [15:0] r_res;
        logic        r_seguir;
        r_res    = i_v;
        r_seguir = 1'b1;
        for (int d = N_DIGITOS - 1; d > 0; d--) begin
            if (r_seguir && (i_v[d*4 +: 4] == 4'h0)) begin
                r_res[d*4 +: 4] = CODIGO_BLANCO;
            end else begin
                r_seguir = 1'b0;
            end
        end
        return r_res;
    endfunction

endpackage

// File: rtl/controlador_barrido_divisor_frecuencia.sv
// Prescaler for the display scan: counts 0..PRESCALE-1 and wraps.
// Ports: i_clk, i_rst_n (async, active-low), o_tick (high on the last count).
// o_tick is combinational from the counter; no backpressure, free running.
module divisor_frecuencia #(
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam logic [PRESCALE_W-1:0] ULTIMO = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_cuenta;
    logic                  w_tick;

    assign w_tick = (r_cuenta == ULTIMO);
    assign o_tick = w_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cuenta <= '0;
        end else if (w_tick) begin
            r_cuenta <= '0;
        end else begin
            r_cuenta <= r_cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_barrido.sv
// Display scan controller: digit index, four frame-stable nibbles, frame pulse.
// Ports: i_clk, i_rst_n, i_valor/i_valido/o_listo (single-entry buffer),
//   o_N_cifra (mux select), o_Datos1..4 (digit nibbles), o_cuadro (frame end).
// Latency capture->display 1..4*PRESCALE cycles; offers while o_listo=0 are dropped.
// Optional macro CONTROLADOR_BARRIDO_BLANK_LEADING_EN: blank leading zeros on load.
module controlador_barrido
    import controlador_barrido_pkg::*;
#(
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_valor,
    input  logic        i_valido,
    output logic        o_listo,
    output logic [1:0]  o_N_cifra,
    output logic [3:0]  o_Datos1,
    output logic [3:0]  o_Datos2,
    output logic [3:0]  o_Datos3,
    output logic [3:0]  o_Datos4,
    output logic        o_cuadro
);

    logic        w_tick;
    logic        w_frontera;
    logic        w_captura;
    logic [15:0] w_carga;

    logic [1:0]  r_n_cifra;
    logic        r_pendiente;
    logic [15:0] r_buffer;
    logic [15:0] r_datos;
    logic        r_cuadro;

    divisor_frecuencia #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_divisor (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (w_tick)
    );

    // The last slot of the last digit closes the frame.
    assign w_frontera = w_tick && (r_n_cifra == CIFRA_4);
    assign w_captura  = i_valido && !r_pendiente;

`ifdef CONTROLADOR_BARRIDO_BLANK_LEADING_EN
    assign w_carga = suprimir_ceros(r_buffer);
`else
    assign w_carga = r_buffer;
`endif

    // Digit index: a 2-bit counter wraps 3 -> 0 on its own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n_cifra <= CIFRA_1;
            r_cuadro  <= 1'b0;
        end else begin
            r_cuadro <= w_frontera;
            if (w_tick) begin
                r_n_cifra <= r_n_cifra + 2'd1;
            end
        end
    end

    // Single-entry buffer. A boundary with a pending value and a capture can
    // never coincide (o_listo is low then), so the two branches are exclusive.
    // A capture on a boundary with an empty buffer only fills the buffer; the
    // display picks it up at the following boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pendiente <= 1'b0;
            r_buffer    <= '0;
            r_datos     <= '0;
        end else if (w_frontera && r_pendiente) begin
            r_datos     <= w_carga;
            r_pendiente <= 1'b0;
        end else if (w_captura) begin
            r_buffer    <= i_valor;
            r_pendiente <= 1'b1;
        end
    end

    assign o_listo   = !r_pendiente;
    assign o_N_cifra = r_n_cifra;
    assign o_Datos1  = r_datos[3:0];
    assign o_Datos2  = r_datos[7:4];
    assign o_Datos3  = r_datos[11:8];
    assign o_Datos4  = r_datos[15:12];
    assign o_cuadro  = r_cuadro;

endmodule

// File: tb/tb_controlador_barrido.sv
// Directed bench for controlador_barrido with PRESCALE=4 (16-cycle frame).
// Accepted values push their expected display image to a queue; each frame
// pulse that should carry a new value pops and compares it.
module tb_controlador_barrido;

    logic        clk;
    logic        i_rst_n;
    logic [15:0] i_valor;
    logic        i_valido;
    logic        o_listo;
    logic [1:0]  o_N_cifra;
    logic [3:0]  o_Datos1, o_Datos2, o_Datos3, o_Datos4;
    logic        o_cuadro;

    int total = 0;
    int bad   = 0;
    logic [15:0] cola[$];

    wire [15:0] disp = {o_Datos4, o_Datos3, o_Datos2, o_Datos1};

    controlador_barrido #(
        .PRESCALE   (4),
        .PRESCALE_W (2)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_valor   (i_valor),
        .i_valido  (i_valido),
        .o_listo   (o_listo),
        .o_N_cifra (o_N_cifra),
        .o_Datos1  (o_Datos1),
        .o_Datos2  (o_Datos2),
        .o_Datos3  (o_Datos3),
        .o_Datos4  (o_Datos4),
        .o_cuadro  (o_cuadro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display image for a captured value.
    function automatic logic [15:0] esperado(input logic [15:0] v);
        logic [15:0] r;
        r = v;
`ifdef CONTROLADOR_BARRIDO_BLANK_LEADING_EN
        if (v[15:12] == 4'h0) r[15:12] = 4'hF;
        if (v[15:8]  == 8'h00) r[11:8] = 4'hF;
        if (v[15:4]  == 12'h000) r[7:4] = 4'hF;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the frame pulse; the display must hold 'prev'
    // on every cycle before it.
    task automatic wait_cuadro(input logic [15:0] prev);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (o_cuadro) seen = 1'b1;
            else chk("hold_before_boundary", disp, prev);
        end
        chk("cuadro_seen", seen, 1);
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (cola.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = cola.pop_front();
            chk(tag, disp, e);
        end
    endtask

    task automatic ofrecer(input logic [15:0] v);
        i_valor  = v;
        i_valido = 1'b1;
        @(negedge clk);
        i_valido = 1'b0;
    endtask

    initial begin
        logic [15:0] vals [3];
        vals[0] = 16'h0000;
        vals[1] = 16'h0105;
        vals[2] = 16'h0010;

        i_rst_n  = 1'b0;
        i_valor  = '0;
        i_valido = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_n_cifra", o_N_cifra, 0);
        chk("rst_datos", disp, 16'h0000);
        chk("rst_listo", o_listo, 1);
        chk("rst_cuadro", o_cuadro, 0);
        i_rst_n = 1'b1;

        // Free-running scan: index changes every 4 cycles, frame pulse every 16
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk($sformatf("scan_idx_k%0d", k), o_N_cifra, (k / 4) % 4);
            chk($sformatf("scan_cuadro_k%0d", k), o_cuadro, (k % 16) == 0);
        end
        chk("idle_datos", disp, 16'h0000);
        chk("idle_listo", o_listo, 1);

        // Mid-frame capture of 1234; ABCD offered while full is dropped
        repeat (5) @(negedge clk);
        cola.push_back(esperado(16'h1234));
        ofrecer(16'h1234);
        chk("listo_after_capture", o_listo, 0);
        ofrecer(16'hABCD);
        chk("listo_still_low", o_listo, 0);
        wait_cuadro(16'h0000);
        pop_chk("display_1234");
        chk("listo_after_load", o_listo, 1);

        // Another frame: display keeps 1234, ABCD never shows
        wait_cuadro(esperado(16'h1234));
        chk("abcd_ignored", disp, esperado(16'h1234));

        // Capture exactly on the boundary cycle with an empty buffer
        repeat (15) @(negedge clk);
        i_valor  = 16'h0042;
        i_valido = 1'b1;
        @(negedge clk);
        i_valido = 1'b0;
        cola.push_back(esperado(16'h0042));
        chk("bnd_cuadro", o_cuadro, 1);
        chk("bnd_no_bypass", disp, esperado(16'h1234));
        chk("bnd_listo", o_listo, 0);
        wait_cuadro(esperado(16'h1234));
        pop_chk("display_0042");

        // Leading-zero patterns
        for (int j = 0; j < 3; j++) begin
            logic [15:0] prev;
            prev = disp;
            cola.push_back(esperado(vals[j]));
            ofrecer(vals[j]);
            wait_cuadro(prev);
            pop_chk($sformatf("display_val%0d", j));
        end

        // Asynchronous reset mid-slot with a value pending
        ofrecer(16'h5555);
        repeat (5) @(negedge clk);
        chk("pre_rst_pending", o_listo, 0);
        chk("pre_rst_idx", o_N_cifra, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_n_cifra", o_N_cifra, 0);
        chk("arst_datos", disp, 16'h0000);
        chk("arst_listo", o_listo, 1);
        chk("arst_cuadro", o_cuadro, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idx0", o_N_cifra, 0);
        @(negedge clk);
        chk("post_rst_idx1", o_N_cifra, 1);
        wait_cuadro(16'h0000);
        chk("pending_discarded", disp, 16'h0000);
        chk("post_rst_listo", o_listo, 1);
        chk("queue_drained", cola.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
